// File: rtl/dphy_rx_ctrl_pkg.sv
// Shared LP line codes and lane state encoding for the D-PHY RX HS controller.
package dphy_rx_ctrl_pkg;

    localparam logic [1:0] LP_STOP = 2'b11;
    localparam logic [1:0] LP_HSRQ = 2'b01;
    localparam logic [1:0] LP_BRDG = 2'b00;
    localparam logic [1:0] LP_ESC  = 2'b10;

    typedef enum logic [2:0] {
        STOP_WAIT,
        STOP,
        HS_RQST,
        BRIDGE,
        SETTLE,
        HS,
        ESC
    } lane_state_e;

endpackage

// File: rtl/dphy_rx_lane_ctrl.sv
// One D-PHY lane: LP synchronizer, glitch filter, request FSM and term/settle timer.
//
// state     | meaning
// STOP_WAIT | after reset or error; waiting for LP-11
// STOP      | LP-11 seen, idle
// HS_RQST   | LP-01 seen, waiting for bridge
// BRIDGE    | LP-00, timing until termination enable
// SETTLE    | termination on, timing until HS receiver enable
// HS        | termination and HS receiver on
// ESC       | escape entry; waits for LP-11, no HS
module dphy_rx_lane_ctrl
    import dphy_rx_ctrl_pkg::*;
#(
    parameter int LP_FILT    = 2,
    parameter int TERM_CNT   = 3,
    parameter int SETTLE_CNT = 8,
    parameter int CNT_W      = 8
) (
    input  logic clk_byte_fr_i,
    input  logic reset_byte_fr_n_i,
    input  logic lp_p,
    input  logic lp_n,
    output logic term_en,
    output logic hs_en,
    output logic err
);

    localparam int RUN_W = $clog2(LP_FILT + 1);

    logic [1:0]       sync_q1, sync_q2, prev_q, filt_q, filt_n;
    logic [RUN_W-1:0] run_q, run_n;
    logic [CNT_W-1:0] cnt_q;
    lane_state_e      state_q;

    // The FSM acts on the filter's next value so the line-to-FSM latency stays at 2+LP_FILT.
    always_comb begin
        run_n  = run_q;
        filt_n = filt_q;
        if (sync_q2 != prev_q) begin
            run_n = RUN_W'(1);
        end else if (run_q != RUN_W'(LP_FILT)) begin
            run_n = run_q + RUN_W'(1);
        end
        if (run_n == RUN_W'(LP_FILT)) begin
            filt_n = sync_q2;
        end
    end

    always_ff @(posedge clk_byte_fr_i) begin
        if (!reset_byte_fr_n_i) begin
            sync_q1 <= LP_STOP;
            sync_q2 <= LP_STOP;
            prev_q  <= LP_STOP;
            filt_q  <= LP_STOP;
            run_q   <= '0;
            cnt_q   <= '0;
            state_q <= STOP_WAIT;
            term_en <= 1'b0;
            hs_en   <= 1'b0;
            err     <= 1'b0;
        end else begin
            sync_q1 <= {lp_p, lp_n};
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
            run_q   <= run_n;
            filt_q  <= filt_n;
            err     <= 1'b0;
            case (state_q)
                STOP_WAIT: begin
                    term_en <= 1'b0;
                    hs_en   <= 1'b0;
                    if (filt_n == LP_STOP) state_q <= STOP;
                end
                STOP: begin
                    term_en <= 1'b0;
                    hs_en   <= 1'b0;
                    if (filt_n == LP_HSRQ) begin
                        state_q <= HS_RQST;
                    end else if (filt_n == LP_ESC) begin
                        state_q <= ESC;
                    end else if (filt_n == LP_BRDG) begin
                        state_q <= STOP_WAIT;
                        err     <= 1'b1;
                    end
                end
                HS_RQST: begin
                    term_en <= 1'b0;
                    hs_en   <= 1'b0;
                    if (filt_n == LP_BRDG) begin
                        state_q <= BRIDGE;
                        cnt_q   <= '0;
                    end else if (filt_n == LP_STOP) begin
                        state_q <= STOP;
                    end else if (filt_n == LP_ESC) begin
                        state_q <= STOP_WAIT;
                        err     <= 1'b1;
                    end
                end
                BRIDGE, SETTLE: begin
                    // Enables are left as-is on LP-11; STOP clears them one edge later.
                    if (filt_n == LP_STOP) begin
                        state_q <= STOP;
                    end else if (filt_n != LP_BRDG) begin
                        state_q <= STOP_WAIT;
                        err     <= 1'b1;
                        term_en <= 1'b0;
                        hs_en   <= 1'b0;
                        cnt_q   <= '0;
                    end else if (state_q == BRIDGE && cnt_q == CNT_W'(TERM_CNT - 1)) begin
                        state_q <= SETTLE;
                        term_en <= 1'b1;
                        cnt_q   <= '0;
                    end else if (state_q == SETTLE && cnt_q == CNT_W'(SETTLE_CNT - 1)) begin
                        state_q <= HS;
                        hs_en   <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HS: begin
                    if (filt_n == LP_STOP) state_q <= STOP;
                end
                ESC: begin
                    term_en <= 1'b0;
                    hs_en   <= 1'b0;
                    if (filt_n == LP_STOP) state_q <= STOP;
                end
                default: begin
                    state_q <= STOP_WAIT;
                    term_en <= 1'b0;
                    hs_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dphy_rx_hs_ctrl.sv
// D-PHY RX termination / HS-enable sequencer: clock lane plus up to four data lanes.
module dphy_rx_hs_ctrl
    import dphy_rx_ctrl_pkg::*;
#(
    parameter int NUM_RX_LANE = 4,
    parameter int LP_FILT     = 2,
    parameter int TERM_CNT    = 3,
    parameter int SETTLE_CNT  = 8,
    parameter int CNT_W       = 8
) (
    input  logic clk_byte_fr_i,
    input  logic reset_byte_fr_n_i,
    input  logic lp_clk_rx_p_i,
    input  logic lp_clk_rx_n_i,
    input  logic lp_d0_rx_p_i,
    input  logic lp_d0_rx_n_i,
    input  logic lp_d1_rx_p_i,
    input  logic lp_d1_rx_n_i,
    input  logic lp_d2_rx_p_i,
    input  logic lp_d2_rx_n_i,
    input  logic lp_d3_rx_p_i,
    input  logic lp_d3_rx_n_i,
    output logic term_clk_en_o,
    output logic term_d0_en_o,
    output logic term_d1_en_o,
    output logic term_d2_en_o,
    output logic term_d3_en_o,
    output logic hs_d0_en_o,
    output logic hs_d1_en_o,
    output logic hs_d2_en_o,
    output logic hs_d3_en_o,
    output logic hs_active_o,
    output logic lp_err_o
);

    localparam logic [4:0] ACT5     = 5'((1 << NUM_RX_LANE) - 1);
    localparam logic [3:0] ACT_MASK = ACT5[3:0];

    logic [3:0] lp_p, lp_n, term_v, hs_v, err_v;
    logic       clk_err, clk_hs_en;

    assign lp_p = {lp_d3_rx_p_i, lp_d2_rx_p_i, lp_d1_rx_p_i, lp_d0_rx_p_i};
    assign lp_n = {lp_d3_rx_n_i, lp_d2_rx_n_i, lp_d1_rx_n_i, lp_d0_rx_n_i};

    // The clock lane's HS enable has no consumer; only its termination is driven out.
    dphy_rx_lane_ctrl #(
        .LP_FILT(LP_FILT), .TERM_CNT(TERM_CNT), .SETTLE_CNT(SETTLE_CNT), .CNT_W(CNT_W)
    ) u_lane_clk (
        .clk_byte_fr_i    (clk_byte_fr_i),
        .reset_byte_fr_n_i(reset_byte_fr_n_i),
        .lp_p             (lp_clk_rx_p_i),
        .lp_n             (lp_clk_rx_n_i),
        .term_en          (term_clk_en_o),
        .hs_en            (clk_hs_en),
        .err              (clk_err)
    );

    for (genvar i = 0; i < 4; i++) begin : g_data
        if (i < NUM_RX_LANE) begin : g_on
            dphy_rx_lane_ctrl #(
                .LP_FILT(LP_FILT), .TERM_CNT(TERM_CNT), .SETTLE_CNT(SETTLE_CNT), .CNT_W(CNT_W)
            ) u_lane (
                .clk_byte_fr_i    (clk_byte_fr_i),
                .reset_byte_fr_n_i(reset_byte_fr_n_i),
                .lp_p             (lp_p[i]),
                .lp_n             (lp_n[i]),
                .term_en          (term_v[i]),
                .hs_en            (hs_v[i]),
                .err              (err_v[i])
            );
        end else begin : g_off
            assign term_v[i] = 1'b0;
            assign hs_v[i]   = 1'b0;
            assign err_v[i]  = 1'b0;
        end
    end

    assign term_d0_en_o = term_v[0];
    assign term_d1_en_o = term_v[1];
    assign term_d2_en_o = term_v[2];
    assign term_d3_en_o = term_v[3];
    assign hs_d0_en_o   = hs_v[0];
    assign hs_d1_en_o   = hs_v[1];
    assign hs_d2_en_o   = hs_v[2];
    assign hs_d3_en_o   = hs_v[3];

    always_ff @(posedge clk_byte_fr_i) begin
        if (!reset_byte_fr_n_i) begin
            hs_active_o <= 1'b0;
            lp_err_o    <= 1'b0;
        end else begin
            hs_active_o <= &(hs_v | ~ACT_MASK);
            lp_err_o    <= (|(err_v & ACT_MASK)) | clk_err;
        end
    end

endmodule

// File: tb/tb_dphy_rx_hs_ctrl.sv
// Scoreboard bench for dphy_rx_hs_ctrl: a 4-lane instance and a 2-lane instance on shared LP lines.
module tb_dphy_rx_hs_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] lp [5];   // 0 = clock lane, 1..4 = d0..d3

    logic       term_clk, hs_act, lp_err;
    logic [3:0] term_d, hs_d;
    logic       term_clk_b, hs_act_b, lp_err_b;
    logic [3:0] term_d_b, hs_d_b;

    dphy_rx_hs_ctrl dut (
        .clk_byte_fr_i(clk), .reset_byte_fr_n_i(rst_n),
        .lp_clk_rx_p_i(lp[0][1]), .lp_clk_rx_n_i(lp[0][0]),
        .lp_d0_rx_p_i(lp[1][1]), .lp_d0_rx_n_i(lp[1][0]),
        .lp_d1_rx_p_i(lp[2][1]), .lp_d1_rx_n_i(lp[2][0]),
        .lp_d2_rx_p_i(lp[3][1]), .lp_d2_rx_n_i(lp[3][0]),
        .lp_d3_rx_p_i(lp[4][1]), .lp_d3_rx_n_i(lp[4][0]),
        .term_clk_en_o(term_clk),
        .term_d0_en_o(term_d[0]), .term_d1_en_o(term_d[1]),
        .term_d2_en_o(term_d[2]), .term_d3_en_o(term_d[3]),
        .hs_d0_en_o(hs_d[0]), .hs_d1_en_o(hs_d[1]),
        .hs_d2_en_o(hs_d[2]), .hs_d3_en_o(hs_d[3]),
        .hs_active_o(hs_act), .lp_err_o(lp_err)
    );

    dphy_rx_hs_ctrl #(.NUM_RX_LANE(2)) dut2 (
        .clk_byte_fr_i(clk), .reset_byte_fr_n_i(rst_n),
        .lp_clk_rx_p_i(lp[0][1]), .lp_clk_rx_n_i(lp[0][0]),
        .lp_d0_rx_p_i(lp[1][1]), .lp_d0_rx_n_i(lp[1][0]),
        .lp_d1_rx_p_i(lp[2][1]), .lp_d1_rx_n_i(lp[2][0]),
        .lp_d2_rx_p_i(lp[3][1]), .lp_d2_rx_n_i(lp[3][0]),
        .lp_d3_rx_p_i(lp[4][1]), .lp_d3_rx_n_i(lp[4][0]),
        .term_clk_en_o(term_clk_b),
        .term_d0_en_o(term_d_b[0]), .term_d1_en_o(term_d_b[1]),
        .term_d2_en_o(term_d_b[2]), .term_d3_en_o(term_d_b[3]),
        .hs_d0_en_o(hs_d_b[0]), .hs_d1_en_o(hs_d_b[1]),
        .hs_d2_en_o(hs_d_b[2]), .hs_d3_en_o(hs_d_b[3]),
        .hs_active_o(hs_act_b), .lp_err_o(lp_err_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Signal ids: 0 term_clk, 1-4 term_d0..3, 5-8 hs_d0..3, 9 hs_active, 10 lp_err,
    // 11-14 two-lane instance term_d2, term_d3, hs_d2, hs_d3, 15 its hs_active.
    function automatic logic sig_val(input int s);
        case (s)
            0:             return term_clk;
            1, 2, 3, 4:    return term_d[s-1];
            5, 6, 7, 8:    return hs_d[s-5];
            9:             return hs_act;
            10:            return lp_err;
            11:            return term_d_b[2];
            12:            return term_d_b[3];
            13:            return hs_d_b[2];
            14:            return hs_d_b[3];
            15:            return hs_act_b;
            default:       return 1'bx;
        endcase
    endfunction

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string tag;
    } sb_t;
    sb_t sbq[$];

    task automatic expect_at(input int dc, input int s, input int v, input string tag);
        sb_t e;
        e.cyc = cyc + dc;
        e.sig = s;
        e.val = v;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                check_val(sbq[i].tag, 32'(sig_val(sbq[i].sig)), 32'(sbq[i].val));
                sbq.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) lp[i] = 2'b11;
        tick(3);

        // reset state, then idle at LP-11
        for (int s = 0; s <= 10; s++) expect_at(0, s, 0, "rst_out");
        rst_n = 1'b1;
        for (int s = 0; s <= 15; s++) expect_at(6, s, 0, "idle_out");
        tick(8);

        // d0 full request: 01 then 00 held, then back to 11
        lp[1] = 2'b01;
        tick(6);
        lp[1] = 2'b00;
        expect_at(6, 1, 0, "d0_term_pre");
        expect_at(7, 1, 1, "d0_term_rise");
        expect_at(14, 5, 0, "d0_hs_pre");
        expect_at(15, 5, 1, "d0_hs_rise");
        expect_at(16, 9, 0, "d0_alone_no_active");
        expect_at(16, 10, 0, "d0_no_err");
        tick(20);
        lp[1] = 2'b11;
        expect_at(4, 1, 1, "d0_term_hold");
        expect_at(4, 5, 1, "d0_hs_hold");
        expect_at(5, 1, 0, "d0_term_fall");
        expect_at(5, 5, 0, "d0_hs_fall");
        tick(8);

        // one-cycle 01 glitch followed by 00: filter must see 11 -> 00 (error, no bridge)
        lp[1] = 2'b01;
        tick(1);
        lp[1] = 2'b00;
        expect_at(4, 10, 0, "glitch_err_pre");
        expect_at(5, 10, 1, "glitch_err_pulse");
        expect_at(6, 10, 0, "glitch_err_end");
        expect_at(8, 1, 0, "glitch_no_term");
        tick(10);
        lp[1] = 2'b11;
        tick(8);

        // d1 escape entry: no error, ignores 01/00 until 11
        lp[2] = 2'b10;
        expect_at(5, 10, 0, "esc_no_err_a");
        expect_at(6, 10, 0, "esc_no_err_b");
        tick(6);
        lp[2] = 2'b01;
        tick(6);
        lp[2] = 2'b00;
        expect_at(6, 10, 0, "esc_no_err_c");
        expect_at(8, 2, 0, "esc_no_term");
        tick(10);
        lp[2] = 2'b11;
        tick(8);

        // d1 11 -> 01 -> 10: single error pulse, no termination
        lp[2] = 2'b01;
        tick(6);
        lp[2] = 2'b10;
        expect_at(4, 10, 0, "rq_err_pre");
        expect_at(5, 10, 1, "rq_err_pulse");
        expect_at(6, 10, 0, "rq_err_end");
        expect_at(8, 2, 0, "rq_err_no_term");
        tick(10);
        lp[2] = 2'b11;
        tick(8);

        // all lanes, d3 lagging 4 cycles
        for (int i = 0; i < 5; i++) lp[i] = 2'b01;
        tick(6);
        for (int i = 0; i < 4; i++) lp[i] = 2'b00;
        expect_at(6, 0, 0, "clk_term_pre");
        expect_at(7, 0, 1, "clk_term_rise");
        expect_at(15, 5, 1, "all_hs_d0");
        expect_at(15, 6, 1, "all_hs_d1");
        expect_at(15, 7, 1, "all_hs_d2");
        expect_at(15, 15, 0, "two_lane_active_pre");
        expect_at(16, 15, 1, "two_lane_active_rise");
        tick(4);
        lp[4] = 2'b00;
        expect_at(14, 8, 0, "d3_hs_pre");
        expect_at(15, 8, 1, "d3_hs_rise");
        expect_at(15, 9, 0, "active_pre");
        expect_at(16, 9, 1, "active_rise");
        for (int s = 11; s <= 14; s++) expect_at(15, s, 0, "two_lane_unused");
        expect_at(16, 10, 0, "all_no_err");
        tick(20);

        // reset while every lane is in HS
        for (int s = 0; s <= 9; s++) expect_at(0, s, 1, "pre_rst_high");
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) lp[i] = 2'b11;
        for (int s = 0; s <= 15; s++) expect_at(1, s, 0, "post_rst_low");
        tick(2);
        rst_n = 1'b1;
        tick(10);

        check_val("sb_drain", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
